// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hazState_t;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
    localparam logic [4:0] REG_X0         = 5'd0;

    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic stallM;
        logic flushD;
        logic flushE;
        logic flushW;
    } stageCtrl_t;

    function automatic logic isLoadUse(
        input logic [1:0] resultSrc,
        input logic       regWrite,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return (resultSrc == RESULTSRC_LOAD) && regWrite && (rd != REG_X0) &&
               ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// and multi-cycle data-memory waits with a timeout trap.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 256,
    parameter int TO_W        = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       Rd_E,
    input  logic             RegWrite_E,
    input  logic [1:0]       ResultSrc_E,
    input  logic             PCSrc_E,
    input  logic             MemAccess_M,
    input  logic             MemReady_M,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic             Mem_Err,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    import pipeline_ctrl_pkg::*;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    hazState_t       state, stateNext;
    logic [TO_W-1:0] waitCnt;
    logic            memHold, loadUse, timeoutHit, branchFlush;
    stageCtrl_t      ctrl;

    assign loadUse    = isLoadUse(ResultSrc_E, RegWrite_E, Rd_E, RS1_D, RS2_D);
    assign memHold    = ((state == RUN) && MemAccess_M && !MemReady_M) ||
                        ((state == MEM_WAIT) && !MemReady_M);
    assign timeoutHit = (state == MEM_WAIT) && !MemReady_M && (waitCnt == WAIT_LAST);
    // A branch parked in E during a wait re-resolves on the release cycle.
    assign branchFlush = rst && (state != ERR) && !memHold && PCSrc_E;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= RUN;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:      if (MemAccess_M && !MemReady_M) stateNext = MEM_WAIT;
            MEM_WAIT: begin
                if (MemReady_M)      stateNext = RUN;
                else if (timeoutHit) stateNext = ERR;
            end
            ERR:      stateNext = ERR;
            default:  stateNext = RUN;
        endcase
    end

    // Held at zero outside MEM_WAIT, so every wait starts counting from 0.
    always_ff @(posedge clk) begin
        if (!rst || (state != MEM_WAIT))
            waitCnt <= '0;
        else if (!MemReady_M && (waitCnt != WAIT_LAST))
            waitCnt <= waitCnt + 1'b1;
    end

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            ctrl.flushD = 1'b1;
            ctrl.flushE = 1'b1;
            ctrl.flushW = 1'b1;
        end else if ((state == ERR) || memHold) begin
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.stallE = 1'b1;
            ctrl.stallM = 1'b1;
            ctrl.flushW = 1'b1;
        end else if (PCSrc_E) begin
            ctrl.flushD = 1'b1;
            ctrl.flushE = 1'b1;
        end else if (loadUse) begin
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.flushE = 1'b1;
        end
    end

    assign Stall_F = ctrl.stallF;
    assign Stall_D = ctrl.stallD;
    assign Stall_E = ctrl.stallE;
    assign Stall_M = ctrl.stallM;
    assign Flush_D = ctrl.flushD;
    assign Flush_E = ctrl.flushE;
    assign Flush_W = ctrl.flushW;
    assign Mem_Err = rst && (state == ERR);

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.stallF),
        .count (Stall_Cnt)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branchFlush),
        .count (Flush_Cnt)
    );

endmodule
